// File: rtl/cpu_defs.sv
// Shared definitions for the cpu core and its downstream trace capture stage.
package cpu_defs;

    localparam int unsigned ADDR_W        = 32;
    localparam int unsigned DATA_W        = 32;
    localparam int unsigned DEFAULT_DEPTH = 16;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] result;
    } trace_entry_t;

    localparam int unsigned ENTRY_W = $bits(trace_entry_t);

endpackage

// File: rtl/trace_fifo.sv
// Show-ahead FIFO with extra-MSB pointers; head slot is presented combinationally.
module trace_fifo
    import cpu_defs::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH,
    parameter int unsigned W     = ENTRY_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_q, wr_d;
    logic [AW:0]  rd_q, rd_d;

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (push) wr_d = wr_q + 1'b1;
        if (pop)  rd_d = rd_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Storage is deliberately left out of reset; only occupancy matters.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q[AW-1:0]] <= wdata;
    end

    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign count = wr_q - rd_q;
    assign rdata = empty ? '0 : mem_q[rd_q[AW-1:0]];

endmodule

// File: rtl/cpu_result_tracer.sv
// Records one {addr, result} entry per change of the core's addr and drains
// them through a valid/ready port, counting captures lost to a full FIFO.
module cpu_result_tracer
    import cpu_defs::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH,
    parameter int unsigned OVF_W = 16
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic [ADDR_W-1:0]        addr,
    input  logic [DATA_W-1:0]        result,
    input  logic                     capture_en,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ADDR_W-1:0]        out_addr,
    output logic [DATA_W-1:0]        out_result,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic [OVF_W-1:0]         overflow_cnt
);

    logic [ADDR_W-1:0] last_addr_q, last_addr_d;
    logic              primed_q, primed_d;
    logic [OVF_W-1:0]  ovf_q, ovf_d;
    logic              req, push, pop, drop;
    trace_entry_t      wr_entry, rd_entry;

    assign req  = capture_en && (!primed_q || (addr != last_addr_q));
    assign pop  = out_valid && out_ready;
    assign push = req && (!full || pop);
    assign drop = req && full && !pop;

    always_comb begin
        last_addr_d = last_addr_q;
        primed_d    = primed_q;
        ovf_d       = ovf_q;
        // The filter advances on every request, even one that gets dropped.
        if (req) begin
            last_addr_d = addr;
            primed_d    = 1'b1;
        end
        if (drop && (ovf_q != '1)) ovf_d = ovf_q + 1'b1;
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            last_addr_q <= '0;
            primed_q    <= 1'b0;
            ovf_q       <= '0;
        end else begin
            last_addr_q <= last_addr_d;
            primed_q    <= primed_d;
            ovf_q       <= ovf_d;
        end
    end

    assign wr_entry.addr   = addr;
    assign wr_entry.result = result;

    trace_fifo #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_fifo (
        .clk   (Clock),
        .rst   (Reset),
        .push  (push),
        .pop   (pop),
        .wdata (wr_entry),
        .rdata (rd_entry),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    assign out_valid    = !empty;
    assign out_addr     = rd_entry.addr;
    assign out_result   = rd_entry.result;
    assign overflow_cnt = ovf_q;

endmodule

// File: tb/tb_cpu_result_tracer.sv
// Directed bench for cpu_result_tracer with DEPTH = 16.
module tb_cpu_result_tracer;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic [31:0] addr = '0;
    logic [31:0] result = '0;
    logic        capture_en = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_addr;
    logic [31:0] out_result;
    logic [4:0]  count;
    logic        full;
    logic        empty;
    logic [15:0] overflow_cnt;

    int errors = 0;
    int checks = 0;

    cpu_result_tracer #(.DEPTH(16), .OVF_W(16)) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .addr         (addr),
        .result       (result),
        .capture_en   (capture_en),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_addr     (out_addr),
        .out_result   (out_result),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .overflow_cnt (overflow_cnt)
    );

    always #5 Clock = ~Clock;

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic do_reset();
        capture_en = 1'b0;
        out_ready  = 1'b0;
        Reset      = 1'b1;
        step();
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        step();
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL reset_flags got empty=%b full=%b exp empty=1 full=0", empty, full); end
        checks++; if (out_valid !== 1'b0 || out_addr !== 32'h0 || out_result !== 32'h0) begin errors++; $display("FAIL reset_out got v=%b a=%h r=%h exp 0", out_valid, out_addr, out_result); end
        checks++; if (overflow_cnt !== 16'd0) begin errors++; $display("FAIL reset_ovf got=%0d exp=0", overflow_cnt); end
        // Held addr 0 after reset: only the first cycle is captured.
        capture_en = 1'b1; addr = 32'h0; result = 32'h1111;
        Reset = 1'b0;
        for (int i = 0; i < 5; i++) step();
        checks++; if (count !== 5'd1) begin errors++; $display("FAIL first_capture_count got=%0d exp=1", count); end
        checks++; if (out_addr !== 32'h0 || out_result !== 32'h1111) begin errors++; $display("FAIL first_capture_entry got a=%h r=%h exp a=0 r=1111", out_addr, out_result); end
        checks++; if (overflow_cnt !== 16'd0) begin errors++; $display("FAIL first_capture_ovf got=%0d exp=0", overflow_cnt); end
        capture_en = 1'b0; out_ready = 1'b1;
        step();
        checks++; if (empty !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL first_pop got empty=%b v=%b exp 1/0", empty, out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_change_filter();
        logic [31:0] av [5] = '{32'h0, 32'h4, 32'h8, 32'h8, 32'hC};
        logic [31:0] rv [5] = '{32'hA0, 32'hA4, 32'hA8, 32'hBAD, 32'hAC};
        logic [31:0] ea [4] = '{32'h0, 32'h4, 32'h8, 32'hC};
        logic [31:0] er [4] = '{32'hA0, 32'hA4, 32'hA8, 32'hAC};
        do_reset();
        capture_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            addr = av[i]; result = rv[i];
            step();
        end
        capture_en = 1'b0;
        checks++; if (count !== 5'd4) begin errors++; $display("FAIL filter_count got=%0d exp=4", count); end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_addr !== ea[i] || out_result !== er[i]) begin
                errors++;
                $display("FAIL filter_pop%0d got v=%b a=%h r=%h exp v=1 a=%h r=%h", i, out_valid, out_addr, out_result, ea[i], er[i]);
            end
            step();
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL filter_drained got empty=%b exp=1", empty); end
        out_ready = 1'b0;
    endtask

    task automatic test_overflow();
        do_reset();
        capture_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            addr = 32'h100 + 32'(i) * 4; result = 32'hC000 + 32'(i);
            step();
        end
        capture_en = 1'b0;
        checks++; if (full !== 1'b1 || count !== 5'd16) begin errors++; $display("FAIL ovf_full got full=%b count=%0d exp 1/16", full, count); end
        checks++; if (overflow_cnt !== 16'd4) begin errors++; $display("FAIL ovf_count got=%0d exp=4", overflow_cnt); end
        checks++; if (out_addr !== 32'h100 || out_result !== 32'hC000) begin errors++; $display("FAIL ovf_head got a=%h r=%h exp a=100 r=c000", out_addr, out_result); end
    endtask

    task automatic test_full_push_pop();
        logic [31:0] ea, er;
        out_ready = 1'b1; capture_en = 1'b1;
        addr = 32'h900; result = 32'h9009;
        step();
        capture_en = 1'b0;
        checks++; if (count !== 5'd16 || full !== 1'b1) begin errors++; $display("FAIL fullpp_count got=%0d full=%b exp 16/1", count, full); end
        checks++; if (overflow_cnt !== 16'd4) begin errors++; $display("FAIL fullpp_ovf got=%0d exp=4", overflow_cnt); end
        for (int i = 1; i <= 16; i++) begin
            ea = (i == 16) ? 32'h900  : 32'h100 + 32'(i) * 4;
            er = (i == 16) ? 32'h9009 : 32'hC000 + 32'(i);
            checks++;
            if (out_valid !== 1'b1 || out_addr !== ea || out_result !== er) begin
                errors++;
                $display("FAIL fullpp_drain%0d got v=%b a=%h r=%h exp v=1 a=%h r=%h", i, out_valid, out_addr, out_result, ea, er);
            end
            step();
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL fullpp_empty got empty=%b exp=1", empty); end
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int bad;
        bad = 0;
        do_reset();
        out_ready = 1'b1; capture_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            addr = 32'h2000 + 32'(i) * 4; result = 32'(i) * 3;
            step();
            checks++;
            if (out_valid !== 1'b1 || out_addr !== addr || out_result !== result || count !== 5'd1) begin
                errors++;
                if (bad++ < 4) $display("FAIL stream%0d got v=%b a=%h r=%h c=%0d exp v=1 a=%h r=%h c=1", i, out_valid, out_addr, out_result, count, addr, result);
            end
        end
        capture_en = 1'b0;
        step();
        checks++; if (empty !== 1'b1 || overflow_cnt !== 16'd0) begin errors++; $display("FAIL stream_end got empty=%b ovf=%0d exp 1/0", empty, overflow_cnt); end
        out_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        capture_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            addr = 32'h3000 + 32'(i) * 4; result = 32'hD0 + 32'(i);
            step();
        end
        capture_en = 1'b0; out_ready = 1'b1;
        step();
        checks++; if (count !== 5'd7 || out_addr !== 32'h3004) begin errors++; $display("FAIL mid_drain got count=%0d a=%h exp 7/3004", count, out_addr); end
        out_ready = 1'b0;
        #3 Reset = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || count !== 5'd0 || out_addr !== 32'h0 || empty !== 1'b1) begin
            errors++; $display("FAIL async_reset got v=%b c=%0d a=%h e=%b exp 0/0/0/1", out_valid, count, out_addr, empty);
        end
        capture_en = 1'b1; result = 32'h5A5A;
        #1 Reset = 1'b0;
        step();
        checks++; if (count !== 5'd1 || out_addr !== 32'h301C || out_result !== 32'h5A5A) begin
            errors++; $display("FAIL post_reset_capture got c=%0d a=%h r=%h exp 1/301c/5a5a", count, out_addr, out_result);
        end
        capture_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_change_filter();
        test_overflow();
        test_full_push_pop();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cpu_result_tracer.md
# cpu_result_tracer

Downstream capture stage for the `cpu` core. It samples the core's `addr`/`result` pair every clock and records one entry each time `addr` changes. Entries go into a FIFO and drain through a valid/ready port to a host, debug UART or bench scoreboard. The block gives a lossless execution trace while the core free-runs, and counts any entries it has to drop.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries. Must be a power of 2, at least 2.
- `OVF_W`, 16: width of the overflow counter.

Ports:
- `Clock` in 1: sole clock. Rising edge active.
- `Reset` in 1: asynchronous, active-high reset.
- `addr` in 32: current instruction address from `cpu`.
- `result` in 32: current result value from `cpu`.
- `capture_en` in 1: enables capture. When low, nothing is pushed.
- `out_valid` out 1: head entry is available.
- `out_ready` in 1: consumer accepts the head entry.
- `out_addr` out 32: `addr` field of the head entry.
- `out_result` out 32: `result` field of the head entry.
- `count` out $clog2(DEPTH)+1: number of occupied entries.
- `full` out 1: `count == DEPTH`.
- `empty` out 1: `count == 0`.
- `overflow_cnt` out OVF_W: number of dropped captures. Saturates at all-ones.

## Operation
- **Change filter.** Register `last_addr` and flag `primed`.
  - A capture request occurs when `capture_en` is high and either `primed` is 0 or `addr != last_addr`.
  - On every capture request, `last_addr <= addr` and `primed <= 1`, whether or not the push is accepted.
- **Push.**
  - A capture request is accepted if `!full`, or if a pop happens in the same cycle.
  - If neither holds, the entry is dropped and `overflow_cnt` increments, saturating at all-ones.
- **Pop.** `out_valid && out_ready`.
  - `out_ready` while empty has no effect.
- **FIFO mechanics.**
  - Read and write pointers are $clog2(DEPTH)+1 bits and wrap modulo 2·DEPTH.
  - `full`/`empty` are derived from the pointer MSB and the remaining bits.
  - `count` is the pointer difference.
- **Show-ahead output.**
  - `out_addr`/`out_result` come directly from the head storage slot.
  - Both are forced to 0 while `empty`.
- **Simultaneous push and pop.**
  - On empty: the push lands and no pop occurs, because `out_valid` was 0.
  - On full: both succeed, `count` stays at DEPTH, and `overflow_cnt` is unchanged.
- **Reset (any time, including mid-drain).**
  - Pointers go to 0 and `primed` to 0.
  - `overflow_cnt` = 0, `count` = 0, `full` = 0, `empty` = 1, `out_valid` = 0, `out_addr` = `out_result` = 0.
  - `last_addr` = 0. Storage contents are not reset.
  - The first capture after reset is always requested, whatever the value of `addr`.
- There is no state machine beyond the FIFO occupancy. All control is pointer/flag based.

## Timing
- Capture latency: an entry pushed at rising edge N appears with `out_valid` = 1 immediately after edge N, so it is poppable at edge N+1.
- Pop at edge N: the next head appears after edge N, with no bubble. Full throughput is one entry per clock in and out.
- `count`, `full`, `empty` and `overflow_cnt` are registered-equivalent: they update only at rising edges.
- `out_*` are combinational from registers and storage only. There is no combinational path from `out_ready` to `out_valid`.
- The consumer may hold `out_ready` high continuously. `out_valid` may deassert only after a pop.

## Structure
- Shared `cpu_defs` package/include holds:
  - `ADDR_W` = 32 and `DATA_W` = 32.
  - The trace entry layout `{addr, result}` (64 bits).
  - The default `DEPTH`.
- One sub-module, `trace_fifo`:
  - Parameterised storage, pointers, `count`/`full`/`empty`, and show-ahead read.
- The top level holds the change filter, push/pop qualification and overflow counter.

## Test plan
1. Reset with `capture_en` = 1 and `addr` held at 0x0 for 5 cycles.
   - Expect exactly 1 entry `{0x0, result}`, `count` = 1, `overflow_cnt` = 0.
2. Drive `addr` 0x0, 0x4, 0x8, 0x8, 0xC with `out_ready` = 0.
   - Expect `count` = 4.
   - Pops return the addresses 0x0, 0x4, 0x8, 0xC in order, with matching results.
3. DEPTH = 16, `out_ready` = 0, drive 20 distinct addresses.
   - Expect `full` = 1, `count` = 16, `overflow_cnt` = 4.
   - The drained entries are the first 16 addresses.
4. With the FIFO full, assert `out_ready` = 1 and push a new address in the same cycle.
   - Expect `count` to stay 16 and `overflow_cnt` unchanged.
   - The head advances and the new entry is at the tail.
5. Continuous stream with `out_ready` = 1.
   - Each entry is seen one cycle after capture.
   - `count` ≤ 1 throughout, and no drops over 40 cycles including pointer wrap.
6. Assert `Reset` asynchronously mid-drain with `count` = 7.
   - Expect `out_valid` = 0, `count` = 0 and `out_addr` = 0 before the next edge.
   - The first post-reset capture is recorded even though `addr` is unchanged.
